// File: rtl/rk_kbd_pkg.sv
// Shared constants, key-set type and scan states for the HID keyboard
// sequencer between the VNC2 receiver and the RK-86 matrix writer.
package rk_kbd_pkg;

  localparam int REPORT_LEN = 8;
  localparam int KEY_SLOTS  = 6;

  localparam logic [7:0] KC_ERR_LO = 8'h01;
  localparam logic [7:0] KC_ERR_HI = 8'h03;
  localparam logic [7:0] KC_F12    = 8'h45;

  localparam int MOD_LCTRL  = 0;
  localparam int MOD_LSHIFT = 1;
  localparam int MOD_LALT   = 2;
  localparam int MOD_RCTRL  = 4;
  localparam int MOD_RSHIFT = 5;

  typedef logic [KEY_SLOTS-1:0][7:0] key_set_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_REL,
    ST_PRS,
    ST_COMMIT
  } scan_state_t;

  function automatic logic has_code(
    input key_set_t   s,
    input logic [7:0] c
  );
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < KEY_SLOTS; i++)
      if (c != 8'h00 && s[i] == c) hit = 1'b1;
    return hit;
  endfunction

  // Rollover/error usages mark a report the keyboard could not resolve.
  function automatic logic is_phantom(input key_set_t s);
    logic ph;
    ph = 1'b0;
    for (int i = 0; i < KEY_SLOTS; i++)
      if (s[i] >= KC_ERR_LO && s[i] <= KC_ERR_HI) ph = 1'b1;
    return ph;
  endfunction

endpackage

// File: rtl/rk_kbd_frame.sv
// Report framer: assembles 8-byte boot reports from the serial stream,
// holds one finished report and resynchronises after a long idle gap.
module rk_kbd_frame
  import rk_kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       clr,
  output logic       frame_rdy,
  output logic       frame_done,
  output logic [7:0] cap_mods,
  output key_set_t   cap_keys,
  output logic       drop
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]    idx;
  logic [TW-1:0] idle_cnt;
  logic          busy;
  logic          accept;

  // The slot being cleared this cycle is free for the next report's byte 0.
  assign busy       = frame_rdy & ~clr;
  assign accept     = rx_valid & ~busy;
  assign frame_done = accept & (idx == 3'(REPORT_LEN - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      idle_cnt  <= '0;
      frame_rdy <= 1'b0;
      cap_mods  <= '0;
      cap_keys  <= '0;
      drop      <= 1'b0;
    end else begin
      drop <= rx_valid & busy;
      if (clr)        frame_rdy <= 1'b0;
      if (frame_done) frame_rdy <= 1'b1;
      if (accept) begin
        idle_cnt <= '0;
        idx      <= idx + 3'd1;
        if (idx == 3'd0)
          cap_mods <= rx_data;
        else if (idx >= 3'd2)
          cap_keys[idx - 3'd2] <= rx_data;
      end else if (idx != 3'd0 && !rx_valid) begin
        if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          idx      <= '0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rk_kbd_hid_ctrl.sv
// HID report to RK-86 key event sequencer: diffs each report against the
// committed key set and hands out releases, then presses, one at a time.
module rk_kbd_hid_ctrl
  import rk_kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_press,
  output logic [7:0] mods,
  output logic [2:0] shift,
  output logic       k_reset,
  output logic       drop
);

  scan_state_t state;
  scan_state_t state_nx;

  key_set_t   cap_keys;
  key_set_t   cur;
  key_set_t   prev;
  logic [7:0] cap_mods;
  logic [7:0] cur_mods;
  logic [2:0] slot;
  logic       frame_rdy;
  logic       frame_done;
  logic       clr;

  logic [7:0] code;
  logic       dup_lower;
  logic       hit;
  logic       adv;
  logic       emit;

  rk_kbd_frame #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .clr       (clr),
    .frame_rdy (frame_rdy),
    .frame_done(frame_done),
    .cap_mods  (cap_mods),
    .cap_keys  (cap_keys),
    .drop      (drop)
  );

  always_comb begin
    code      = 8'h00;
    dup_lower = 1'b0;
    hit       = 1'b0;
    for (int i = 0; i < KEY_SLOTS; i++)
      if (3'(i) < slot && cur[i] == cur[slot]) dup_lower = 1'b1;
    unique case (state)
      ST_REL: begin
        code = prev[slot];
        hit  = code != 8'h00 && !has_code(cur, code);
      end
      ST_PRS: begin
        code = cur[slot];
        hit  = code != 8'h00 && !has_code(prev, code) && !dup_lower;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    adv      = 1'b0;
    emit     = 1'b0;
    unique case (state)
      ST_IDLE:
        if (frame_rdy | frame_done) state_nx = ST_LOAD;
      ST_LOAD: begin
        clr      = 1'b1;
        state_nx = is_phantom(cap_keys) ? ST_IDLE : ST_REL;
      end
      ST_REL, ST_PRS: begin
        if (ev_valid)  adv  = ev_ready;
        else if (hit)  emit = 1'b1;
        else           adv  = 1'b1;
        if (adv && slot == 3'(KEY_SLOTS - 1))
          state_nx = (state == ST_REL) ? ST_PRS : ST_COMMIT;
      end
      ST_COMMIT:
        state_nx = ST_IDLE;
      default:
        state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cur      <= '0;
      cur_mods <= '0;
      prev     <= '0;
      slot     <= '0;
      ev_valid <= 1'b0;
      ev_code  <= '0;
      ev_press <= 1'b0;
      mods     <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_LOAD) begin
        cur      <= cap_keys;
        cur_mods <= cap_mods;
        slot     <= '0;
      end else if (adv) begin
        slot <= (slot == 3'(KEY_SLOTS - 1)) ? 3'd0 : slot + 3'd1;
      end
      if (emit) begin
        ev_valid <= 1'b1;
        ev_code  <= code;
        ev_press <= (state == ST_PRS);
      end else if (ev_valid && ev_ready) begin
        ev_valid <= 1'b0;
      end
      if (state == ST_COMMIT) begin
        prev <= cur;
        mods <= cur_mods;
      end
    end
  end

  assign shift = {mods[MOD_LALT],
                  mods[MOD_LCTRL] | mods[MOD_RCTRL],
                  mods[MOD_LSHIFT] | mods[MOD_RSHIFT]};

  assign k_reset = has_code(prev, KC_F12);

endmodule

// File: tb/tb_rk_kbd_hid_ctrl.sv
// Self-checking bench for rk_kbd_hid_ctrl: directed scenarios plus random
// reports against a set-difference reference model.
module tb_rk_kbd_hid_ctrl;

  localparam int TO = 64;

  typedef logic [7:0] rep_t [8];

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       ev_ready = 1'b1;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_press;
  logic [7:0] mods;
  logic [2:0] shift;
  logic       k_reset;
  logic       drop;

  int n_pass = 0;
  int n_total = 0;
  int base = 0;
  int drop_cnt = 0;

  logic [8:0] got_q [$];
  logic [8:0] exp_q [$];
  logic [7:0] m_prev [6];
  logic [7:0] m_mods;

  rk_kbd_hid_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk     (clk),
    .reset   (reset),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_code (ev_code),
    .ev_press(ev_press),
    .mods    (mods),
    .shift   (shift),
    .k_reset (k_reset),
    .drop    (drop)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ev_valid && ev_ready) got_q.push_back({ev_press, ev_code});
    if (drop) drop_cnt++;
  end

  function automatic logic in_rep(input rep_t r, input logic [7:0] c);
    for (int s = 0; s < 6; s++) if (r[s+2] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic in_prev(input logic [7:0] c);
    for (int s = 0; s < 6; s++) if (m_prev[s] == c) return 1'b1;
    return 1'b0;
  endfunction

  // Releases = prev \ cur in prev slot order; presses = cur \ prev, first copy only.
  function automatic void model(input rep_t r);
    logic ph;
    logic dup;
    ph = 1'b0;
    for (int s = 0; s < 6; s++)
      if (r[s+2] >= 8'h01 && r[s+2] <= 8'h03) ph = 1'b1;
    if (ph) return;
    for (int s = 0; s < 6; s++)
      if (m_prev[s] != 0 && !in_rep(r, m_prev[s]))
        exp_q.push_back({1'b0, m_prev[s]});
    for (int s = 0; s < 6; s++) begin
      dup = 1'b0;
      for (int j = 0; j < s; j++) if (r[j+2] == r[s+2]) dup = 1'b1;
      if (r[s+2] != 0 && !in_prev(r[s+2]) && !dup)
        exp_q.push_back({1'b1, r[s+2]});
    end
    for (int s = 0; s < 6; s++) m_prev[s] = r[s+2];
    m_mods = r[0];
  endfunction

  function automatic logic [2:0] m_shift();
    return {m_mods[2], m_mods[0] | m_mods[4], m_mods[1] | m_mods[5]};
  endfunction

  function automatic logic m_kreset();
    return in_prev(8'h45);
  endfunction

  function automatic rep_t mk(input logic [7:0] m, input logic [7:0] k0,
                              input logic [7:0] k1 = 8'h00);
    rep_t r;
    r = '{m, 8'h00, k0, k1, 8'h00, 8'h00, 8'h00, 8'h00};
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_rep(input rep_t r);
    for (int i = 0; i < 8; i++) send_byte(r[i]);
  endtask

  task automatic apply(input rep_t r);
    model(r);
    send_rep(r);
    idle(40);
  endtask

  task automatic begin_test;
    base = got_q.size();
    exp_q.delete();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle(3);
    n_total++;
    if ({ev_valid, ev_code, ev_press, mods, shift, k_reset, drop} !== 23'd0)
      $display("FAIL reset_held outputs=%h want 0",
               {ev_valid, ev_code, ev_press, mods, shift, k_reset, drop});
    else n_pass++;
    reset = 1'b0;
    for (int s = 0; s < 6; s++) m_prev[s] = 8'h00;
    m_mods = 8'h00;
    idle(3);
    n_total++;
    if ({ev_valid, ev_code, ev_press, mods, shift, k_reset, drop} !== 23'd0)
      $display("FAIL reset_after outputs=%h want 0",
               {ev_valid, ev_code, ev_press, mods, shift, k_reset, drop});
    else n_pass++;
  endtask

  task automatic test_press_release;
    begin_test;
    apply(mk(8'h00, 8'h00));
    apply(mk(8'h00, 8'h04));
    apply(mk(8'h00, 8'h00));
    n_total++;
    if (got_q.size() - base != exp_q.size())
      $display("FAIL pr_count got %0d want %0d", got_q.size() - base, exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      n_total++;
      if (got_q[base+i] !== exp_q[i])
        $display("FAIL pr_ev%0d got %h want %h", i, got_q[base+i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_mods;
    begin_test;
    apply(mk(8'h00, 8'h04));
    apply(mk(8'h02, 8'h04, 8'h05));
    n_total++;
    if (got_q.size() - base != exp_q.size())
      $display("FAIL mods_count got %0d want %0d", got_q.size() - base, exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      n_total++;
      if (got_q[base+i] !== exp_q[i])
        $display("FAIL mods_ev%0d got %h want %h", i, got_q[base+i], exp_q[i]);
      else n_pass++;
    end
    n_total++;
    if (shift !== m_shift() || mods !== m_mods)
      $display("FAIL mods_shift got %b/%h want %b/%h", shift, mods, m_shift(), m_mods);
    else n_pass++;
  endtask

  task automatic test_order;
    begin_test;
    apply(mk(8'h00, 8'h05, 8'h06));
    n_total++;
    if (got_q.size() - base != exp_q.size())
      $display("FAIL order_count got %0d want %0d", got_q.size() - base, exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      n_total++;
      if (got_q[base+i] !== exp_q[i])
        $display("FAIL order_ev%0d got %h want %h", i, got_q[base+i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_timing;
    logic [2:0] sh_before;
    begin_test;
    sh_before = m_shift();
    model(mk(8'h02, 8'h05, 8'h06));
    send_rep(mk(8'h02, 8'h05, 8'h06));
    idle(13);
    n_total++;
    if (shift !== sh_before)
      $display("FAIL timing_t14 shift got %b want %b", shift, sh_before);
    else n_pass++;
    idle(1);
    n_total++;
    if (shift !== m_shift() || mods !== m_mods)
      $display("FAIL timing_t15 got %b/%h want %b/%h", shift, mods, m_shift(), m_mods);
    else n_pass++;
    idle(10);
    n_total++;
    if (got_q.size() - base != 0)
      $display("FAIL timing_events got %0d want 0", got_q.size() - base);
    else n_pass++;
  endtask

  task automatic test_stall;
    logic [7:0] c0;
    logic       p0;
    logic       ok;
    int         w;
    begin_test;
    ev_ready = 1'b0;
    model(mk(8'h00, 8'h07, 8'h08));
    send_rep(mk(8'h00, 8'h07, 8'h08));
    w = 0;
    while (!ev_valid && w < 40) begin
      idle(1);
      w++;
    end
    n_total++;
    if (ev_valid !== 1'b1) $display("FAIL stall_wait ev_valid=%b want 1", ev_valid);
    else n_pass++;
    c0 = ev_code;
    p0 = ev_press;
    n_total++;
    if ({p0, c0} !== exp_q[0])
      $display("FAIL stall_first got %h want %h", {p0, c0}, exp_q[0]);
    else n_pass++;
    ok = 1'b1;
    repeat (20) begin
      idle(1);
      if (ev_valid !== 1'b1 || ev_code !== c0 || ev_press !== p0) ok = 1'b0;
    end
    n_total++;
    if (!ok) $display("FAIL stall_hold got %b/%h want 1/%h", ev_valid, ev_code, c0);
    else n_pass++;
    n_total++;
    if (got_q.size() != base)
      $display("FAIL stall_leak got %0d want 0", got_q.size() - base);
    else n_pass++;
    ev_ready = 1'b1;
    idle(40);
    n_total++;
    if (got_q.size() - base != exp_q.size())
      $display("FAIL stall_count got %0d want %0d", got_q.size() - base, exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      n_total++;
      if (got_q[base+i] !== exp_q[i])
        $display("FAIL stall_ev%0d got %h want %h", i, got_q[base+i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_drop;
    int d0;
    begin_test;
    ev_ready = 1'b0;
    d0 = drop_cnt;
    model(mk(8'h00, 8'h09));
    send_rep(mk(8'h00, 8'h09));
    model(mk(8'h00, 8'h0a, 8'h09));
    send_rep(mk(8'h00, 8'h0a, 8'h09));
    send_byte(8'h55);
    idle(3);
    n_total++;
    if (drop_cnt - d0 != 1) $display("FAIL drop_pulses got %0d want 1", drop_cnt - d0);
    else n_pass++;
    ev_ready = 1'b1;
    idle(80);
    n_total++;
    if (got_q.size() - base != exp_q.size())
      $display("FAIL drop_count got %0d want %0d", got_q.size() - base, exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      n_total++;
      if (got_q[base+i] !== exp_q[i])
        $display("FAIL drop_ev%0d got %h want %h", i, got_q[base+i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_timeout;
    begin_test;
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h0b);
    send_byte(8'h0c);
    idle(TO + 1);
    apply(mk(8'h00, 8'h0a, 8'h0d));
    n_total++;
    if (got_q.size() - base != exp_q.size())
      $display("FAIL tmo_count got %0d want %0d", got_q.size() - base, exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      n_total++;
      if (got_q[base+i] !== exp_q[i])
        $display("FAIL tmo_ev%0d got %h want %h", i, got_q[base+i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_phantom;
    begin_test;
    apply(mk(8'h10, 8'h01, 8'h0e));
    n_total++;
    if (got_q.size() - base != 0 || mods !== m_mods)
      $display("FAIL phantom got %0d ev mods %h want 0 ev mods %h",
               got_q.size() - base, mods, m_mods);
    else n_pass++;
    apply(mk(8'h00, 8'h0a, 8'h0d));
    n_total++;
    if (got_q.size() - base != 0)
      $display("FAIL phantom_prev got %0d want 0", got_q.size() - base);
    else n_pass++;
    apply(mk(8'h00, 8'h45));
    n_total++;
    if (k_reset !== m_kreset()) $display("FAIL f12 k_reset got %b want %b", k_reset, m_kreset());
    else n_pass++;
    n_total++;
    if (got_q.size() - base != exp_q.size())
      $display("FAIL f12_count got %0d want %0d", got_q.size() - base, exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      n_total++;
      if (got_q[base+i] !== exp_q[i])
        $display("FAIL f12_ev%0d got %h want %h", i, got_q[base+i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    int w;
    begin_test;
    apply(mk(8'h22, 8'h45));
    ev_ready = 1'b0;
    send_rep(mk(8'h22, 8'h45, 8'h04));
    w = 0;
    while (!ev_valid && w < 40) begin
      idle(1);
      w++;
    end
    n_total++;
    if (ev_valid !== 1'b1 || ev_press !== 1'b1)
      $display("FAIL rmid_wait got %b/%b want 1/1", ev_valid, ev_press);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_total++;
    if ({ev_valid, ev_code, ev_press, mods, shift, k_reset, drop} !== 23'd0)
      $display("FAIL rmid_clear outputs=%h want 0",
               {ev_valid, ev_code, ev_press, mods, shift, k_reset, drop});
    else n_pass++;
    idle(2);
    reset = 1'b0;
    ev_ready = 1'b1;
    for (int s = 0; s < 6; s++) m_prev[s] = 8'h00;
    m_mods = 8'h00;
    idle(40);
    n_total++;
    if (got_q.size() != base)
      $display("FAIL rmid_abort got %0d want 0", got_q.size() - base);
    else n_pass++;
    begin_test;
    apply(mk(8'h00, 8'h04));
    n_total++;
    if (got_q.size() - base != 1 || got_q[got_q.size()-1] !== exp_q[0])
      $display("FAIL rmid_fresh got %0d ev want %h", got_q.size() - base, exp_q[0]);
    else n_pass++;
  endtask

  task automatic test_random;
    rep_t r;
    int   v;
    int   bad;
    begin_test;
    bad = 0;
    for (int n = 0; n < 40; n++) begin
      r[0] = 8'($urandom);
      r[1] = 8'($urandom);
      for (int s = 0; s < 6; s++) begin
        v = $urandom_range(0, 9);
        r[s+2] = (v < 3) ? 8'h00 : (v == 9) ? 8'h45 : 8'(v + 1);
      end
      if ($urandom_range(0, 7) == 0) r[$urandom_range(2, 7)] = 8'($urandom_range(1, 3));
      model(r);
      send_rep(r);
      repeat (60) begin
        ev_ready = ($urandom_range(0, 3) != 0);
        idle(1);
      end
      ev_ready = 1'b1;
      idle(40);
      if (mods !== m_mods || shift !== m_shift() || k_reset !== m_kreset()) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL rnd_state got %0d bad reports want 0", bad);
    else n_pass++;
    n_total++;
    if (got_q.size() - base != exp_q.size())
      $display("FAIL rnd_count got %0d want %0d", got_q.size() - base, exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      n_total++;
      if (got_q[base+i] !== exp_q[i])
        $display("FAIL rnd_ev%0d got %h want %h", i, got_q[base+i], exp_q[i]);
      else n_pass++;
    end
  endtask

  initial begin
    #2;
    test_reset;
    test_press_release;
    test_mods;
    test_order;
    test_timing;
    test_stall;
    test_drop;
    test_timeout;
    test_phantom;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rk_kbd_hid_ctrl.md
# rk_kbd_hid_ctrl

Sequencer between the VNC2 serial byte receiver and the RK-86 keyboard matrix. It frames 8-byte USB HID boot-keyboard reports from the received byte stream and diffs each report against the previously committed key set. It then issues one press or release event per changed keycode to the matrix writer over a valid/ready handshake. It also owns the modifier byte, the `shift[2:0]` lines and the F12 reset request.

## Interface
- `TIMEOUT_CYCLES`, 50000: maximum idle clk cycles between bytes of one report before the framer resynchronises.
- `clk` in 1: system clock.
- `reset` in 1: reset, asynchronous, active-high.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe qualifying `rx_data`.
- `ev_valid` out 1: key event pending.
- `ev_ready` in 1: matrix writer accepts the event.
- `ev_code` out 8: HID usage code of the event.
- `ev_press` out 1: 1 = press, 0 = release.
- `mods` out 8: committed HID modifier byte.
- `shift` out 3: [0]=mods[1]|mods[5], [1]=mods[0]|mods[4], [2]=mods[2].
- `k_reset` out 1: high while usage 0x45 (F12) is in the committed key set.
- `drop` out 1: one-cycle pulse when a byte is discarded because a completed report is still waiting.

## Operation
- Framer: byte index 0..7. Byte 0 is the modifier byte, byte 1 is reserved and ignored, bytes 2..7 are key slots 0..5, stored in the capture buffer. When byte 7 is stored, `frame_rdy` is set.
- Framer resync: if the index is non-zero and TIMEOUT_CYCLES cycles pass with no `rx_valid`, the index returns to 0 and partial data is discarded.
- While `frame_rdy`=1, incoming bytes are not stored. Each one pulses `drop` and the index is not advanced.
- Phantom report: any key slot holding 0x01..0x03 (rollover/error). The whole report is discarded with no events and no commit, and `frame_rdy` is cleared.
- FSM states: IDLE, LOAD, REL, PRS, COMMIT.
- IDLE -> LOAD when `frame_rdy`=1. LOAD copies capture to `cur`, clears `frame_rdy` and resets the slot counter to 0.
- REL steps slots 0..5 of `prev`. For each slot, if the code is non-zero and absent from `cur`, it emits a release.
- PRS steps slots 0..5 of `cur`. For each slot, if the code is non-zero, absent from `prev`, and not already present in a lower `cur` slot, it emits a press.
- Releases are always emitted before presses.
- COMMIT sets `prev` <= `cur` and `mods` <= captured byte 0, then goes to IDLE.
- Emitting an event loads `ev_code`/`ev_press` and sets `ev_valid`. The scan stalls until `ev_valid & ev_ready`, then advances.
- Reset values: all buffers 0, `prev` empty, `ev_valid`=0, `ev_code`=0, `ev_press`=0, `mods`=0, `shift`=0, `k_reset`=0, `drop`=0, FSM=IDLE, index 0.
- Reset mid-scan aborts with no further events. After reset, all keys are treated as released.

## Timing
- 8th byte strobe at cycle T: `frame_rdy` is high at T+1, LOAD at T+1 if IDLE, first slot evaluated at T+2.
- Each slot takes 1 cycle when no event is emitted. An event is registered and `ev_valid` is visible the cycle after its slot is evaluated. It is accepted in the first cycle with `ev_ready`=1, and the scan resumes the next cycle.
- Report with no changes: REL at T+2..T+7, PRS at T+8..T+13, COMMIT at T+14. `mods`/`shift`/`k_reset` are updated from T+15.
- `ev_code`/`ev_press` must stay stable while `ev_valid`=1 and `ev_ready`=0.
- A `rx_valid` in the same cycle that LOAD clears `frame_rdy` is stored as byte 0 of the next report, not dropped.

## Structure
- Package `rk_kbd_pkg`:
  - REPORT_LEN=8, KEY_SLOTS=6.
  - KC_ERR_LO=8'h01, KC_ERR_HI=8'h03, KC_F12=8'h45.
  - Modifier bit indices.
  - FSM state enum.
- Sub-module `rk_kbd_frame`: byte index, timeout counter, capture buffer, `frame_rdy`, `drop`.
- Top module: scan FSM, membership comparators and event register.

## Test plan
- Empty report followed by 00 00 04 00 00 00 00 00 -> exactly one event {0x04, press}. Then all-zero report -> one event {0x04, release}.
- Report 02 00 04 05 00 00 00 00 after committed {04} -> one event, press 0x05. `shift`=3'b001 from T+15.
- Committed {04,05}, new report 00 00 05 06 00 00 00 00 -> release 0x04, then press 0x06, in that order.
- Hold `ev_ready`=0 for 20 cycles on the first event -> `ev_valid` and `ev_code` stay stable, no other event is emitted, and the scan resumes after acceptance.
- 4 bytes, then an idle gap of TIMEOUT_CYCLES+1, then a full 8-byte report -> exactly one report processed, equal to the last 8 bytes.
- Report with 0x01 in slot 0 -> no events and `prev` unchanged. Report 00 00 45 … -> `k_reset`=1. Assert `reset` mid-PRS -> all outputs return to 0 immediately.
